matrix_fifo_ctrl: RTL and testbench
===================================

Name: matrix_fifo_ctrl

Overview:
- Sequences the matrix FIFO (push/pop pointer block) through one full load/drain transaction of an N×N matrix.
- Load phase: accepts N*N elements from an upstream valid/ready source and drives `push`.
- Drain phase: drives `pop` toward a downstream consumer, tagging each element with row/column indices and a last-in-row flag.
- Sits between the matrix loader, the FIFO pointers and the multiply datapath.

Parameters:
- N_W, 4, width of the matrix dimension N (nibble).
- MAX_N, 8, largest legal N; any N > MAX_N is rejected.
- CNT_W, 2*N_W+1, width of the element counter (holds N*N inclusive).
- TIMEOUT, 255, idle-cycle limit for the optional watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a transaction; sampled in IDLE only
- n_in  in  N_W  matrix dimension N, latched on accepted start
- in_valid  in  1  upstream element valid
- in_ready  out  1  controller can accept an element
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_ready  in  1  FIFO reports N*N elements stored
- push  out  1  FIFO write strobe
- pop  out  1  FIFO read strobe
- out_valid  out  1  FIFO head element valid to consumer
- out_ready  in  1  consumer accepts element
- row_idx  out  N_W  row index of current output element
- col_idx  out  N_W  column index of current output element
- row_last  out  1  current output element is col N-1
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse, transaction complete
- err  out  1  one-cycle pulse, illegal N / protocol fault / timeout

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is synchronous, active-high.
  - On reset: state=IDLE and counters=0. All outputs are 0 except `row_last`, which follows its combinational definition.
  - A reset asserted mid-transaction aborts to IDLE with no done/err pulse and no further push/pop.
- State machine (IDLE, LOAD, DRAIN, DONE):
  - IDLE: start && 1<=n_in<=MAX_N → latch N, clear counters, go to LOAD. start with n_in=0 or n_in>MAX_N → err pulse next cycle, stay IDLE.
  - LOAD:
    - in_ready = !fifo_full.
    - push = in_valid && in_ready. Each push increments load_cnt.
    - When load_cnt reaches N*N (the push that makes it N*N is the last), go to DRAIN.
    - If fifo_ready is not 1 in the first DRAIN cycle → err pulse; DRAIN proceeds anyway.
  - DRAIN:
    - out_valid = !fifo_empty; pop = out_valid && out_ready.
    - On each pop, col_idx increments. At col N-1, col_idx wraps to 0 and row_idx increments.
    - The pop at (N-1, N-1) → DONE.
    - fifo_empty while pops remain is a stall, not an error.
  - DONE: done=1 for exactly one cycle → IDLE.
- Signal rules:
  - push and pop are never asserted in the same cycle.
  - start outside IDLE is ignored.
  - row_idx/col_idx are registered and change only on pop.
  - row_last = DRAIN && col_idx==N-1.
  - All N*N arithmetic is done in CNT_W bits. No wrap is possible for N<=MAX_N.
- Latency:
  - start to first in_ready: 1 cycle.
  - Last pop to done: 1 cycle.
  - Minimum transaction length: 2*N*N+2 cycles.

Optional Feature:
- Macro: MATRIX_FIFO_CTRL_TIMEOUT_EN.
- Defined: a watchdog counts consecutive LOAD cycles without a push, or DRAIN cycles without a pop. On reaching TIMEOUT: err pulse, abort to IDLE. The FIFO contents are left to the system to flush.
- Undefined: no watchdog logic; stalls last indefinitely.

Decomposition:
- Shared package `fifo_pkg` holds:
  - ctrl_state_t enum (IDLE, LOAD, DRAIN, DONE);
  - element counter type (CNT_W bits);
  - MAX_N and TIMEOUT constants.
  - It reuses the existing nibble type for N.
- One sub-module: `rc_index_counter`, a row/column counter with enable, clear, N limit and row_last/last outputs.

Test Plan:
- N=2, in_valid always 1, out_ready always 1 → 4 pushes in consecutive cycles, then 4 pops. Indices (0,0)(0,1)(1,0)(1,1); row_last on the 2nd and 4th pops; done one cycle after the 4th pop; busy drops with done.
- N=3 with out_ready toggling 1,0 → 9 pops, one every other cycle. Indices hold during stalls; done exactly once.
- start with n_in=0, then with n_in=9 → err pulse each time; busy stays 0; no push.
- N=4, rst asserted after 5 pushes → next cycle: IDLE, busy=0, in_ready=0, no done/err. A new start with N=2 completes normally.
- fifo_full forced 1 during LOAD for 3 cycles → in_ready=0 and no push for those 3 cycles, then loading resumes.
- With MATRIX_FIFO_CTRL_TIMEOUT_EN, N=2, in_valid held 0 after start → err after 255 idle cycles, then IDLE.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the matrix FIFO controller.
package fifo_pkg;

  localparam int N_W     = 4;
  localparam int MAX_N   = 8;
  localparam int CNT_W   = 2*N_W + 1;
  localparam int TIMEOUT = 255;
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  typedef logic [N_W-1:0]   nibble_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [WD_W-1:0]  wd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } ctrl_state_t;

  // Element count of an N x N matrix, widened before multiplying.
  function automatic cnt_t elem_count(nibble_t n);
    return cnt_t'(n) * cnt_t'(n);
  endfunction

endpackage

// File: rtl/matrix_fifo_ctrl_rc_index_counter.sv
// Row/column index counter for an N x N traversal; advances on en_i, clears on clr_i.
module rc_index_counter
  import fifo_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [N_W-1:0] n_i,
  output logic [N_W-1:0] row_o,
  output logic [N_W-1:0] col_o,
  output logic           row_last_o,
  output logic           last_o
);

  nibble_t row_q, row_d;
  nibble_t col_q, col_d;

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign row_last_o = (col_q == n_i - nibble_t'(1));
  assign last_o     = row_last_o && (row_q == n_i - nibble_t'(1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (row_last_o) begin
        col_d = '0;
        row_d = row_q + nibble_t'(1);
      end else begin
        col_d = col_q + nibble_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/matrix_fifo_ctrl.sv
// Load/drain sequencer for one N x N matrix pass through the FIFO.
// Optional watchdog abort enabled by defining MATRIX_FIFO_CTRL_TIMEOUT_EN.
module matrix_fifo_ctrl
  import fifo_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n_in,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           fifo_full,
  input  logic           fifo_empty,
  input  logic           fifo_ready,
  output logic           push,
  output logic           pop,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] row_idx,
  output logic [N_W-1:0] col_idx,
  output logic           row_last,
  output logic           busy,
  output logic           done,
  output logic           err
);

  ctrl_state_t state_q, state_d;
  nibble_t     n_q, n_d;
  cnt_t        load_cnt_q, load_cnt_d;
  logic        chk_q, chk_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        idx_clr, idx_row_last, idx_last;
  logic        n_legal;

  assign n_legal   = (n_in != '0) && (n_in <= nibble_t'(MAX_N));
  assign idx_clr   = (state_q == IDLE) && start && n_legal;

  // Strobes stay combinational so a full/empty flag gates them the same cycle.
  assign in_ready  = (state_q == LOAD) && !fifo_full;
  assign push      = in_ready && in_valid;
  assign out_valid = (state_q == DRAIN) && !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign row_last  = (state_q == DRAIN) && idx_row_last;

  rc_index_counter u_idx (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (idx_clr),
    .en_i       (pop),
    .n_i        (n_q),
    .row_o      (row_idx),
    .col_o      (col_idx),
    .row_last_o (idx_row_last),
    .last_o     (idx_last)
  );

`ifdef MATRIX_FIFO_CTRL_TIMEOUT_EN
  wd_t  wd_q, wd_d;
  logic wd_fire;

  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if ((state_q == LOAD || state_q == DRAIN) && !push && !pop) begin
      wd_d    = wd_q + wd_t'(1);
      wd_fire = (wd_q == wd_t'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    load_cnt_d = load_cnt_q;
    chk_d      = chk_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_legal) begin
            n_d        = n_in;
            load_cnt_d = '0;
            state_d    = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (push) begin
          load_cnt_d = load_cnt_q + cnt_t'(1);
          if (load_cnt_d == elem_count(n_q)) begin
            state_d = DRAIN;
            chk_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        // FIFO should report a full matrix on entry; flag but keep draining.
        chk_d = 1'b0;
        if (chk_q && !fifo_ready) err_d = 1'b1;
        if (pop && idx_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MATRIX_FIFO_CTRL_TIMEOUT_EN
    if (wd_fire) begin
      state_d = IDLE;
      chk_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      load_cnt_q <= '0;
      chk_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      load_cnt_q <= load_cnt_d;
      chk_q      <= chk_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_matrix_fifo_ctrl.sv
// Directed bench for matrix_fifo_ctrl with a count-based reference model.
module tb_matrix_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] n_in = '0;
  logic       in_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty = 1'b0;
  logic       fifo_ready = 1'b1;
  logic       out_ready = 1'b0;
  logic       in_ready, push, pop, out_valid, row_last, busy, done, err;
  logic [3:0] row_idx, col_idx;

  matrix_fifo_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_ready(fifo_ready),
    .push(push), .pop(pop), .out_valid(out_valid), .out_ready(out_ready),
    .row_idx(row_idx), .col_idx(col_idx), .row_last(row_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  bit chk_on = 0;

  // reference model: phase 0 idle, 1 load, 2 drain, 3 done
  int m_phase = 0, m_n = 0, m_pushes = 0, m_pops = 0, m_first = 0;
  int m_err = 0, m_done = 0, m_stall = 0;
  int e_in_ready, e_push, e_out_valid, e_pop, e_row, e_col, e_row_last, e_busy;

  // event log
  int push_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  int pop_log[$];
  int pop_cyc[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_now();
    e_in_ready  = (m_phase == 1 && !fifo_full) ? 1 : 0;
    e_push      = (e_in_ready == 1 && in_valid) ? 1 : 0;
    e_out_valid = (m_phase == 2 && !fifo_empty) ? 1 : 0;
    e_pop       = (e_out_valid == 1 && out_ready) ? 1 : 0;
    e_row       = (m_n != 0) ? m_pops / m_n : 0;
    e_col       = (m_n != 0) ? m_pops % m_n : 0;
    e_row_last  = (m_phase == 2 && m_n != 0 && (m_pops % m_n) == m_n - 1) ? 1 : 0;
    e_busy      = (m_phase != 0) ? 1 : 0;
  endtask

  task automatic compare_now();
    expect_now();
    if (chk_on) begin
      chk("in_ready",  int'(in_ready),  e_in_ready);
      chk("push",      int'(push),      e_push);
      chk("out_valid", int'(out_valid), e_out_valid);
      chk("pop",       int'(pop),       e_pop);
      chk("row_idx",   int'(row_idx),   e_row);
      chk("col_idx",   int'(col_idx),   e_col);
      chk("row_last",  int'(row_last),  e_row_last);
      chk("busy",      int'(busy),      e_busy);
      chk("done",      int'(done),      m_done);
      chk("err",       int'(err),       m_err);
      chk("push_pop_excl", int'(push && pop), 0);
    end
    if (push) push_cnt++;
    if (pop) begin
      pop_log.push_back((int'(row_idx) << 8) | (int'(col_idx) << 4) | int'(row_last));
      pop_cyc.push_back(cyc);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err)  begin err_cnt++;  err_cyc  = cyc; end
  endtask

  task automatic model_step();
    int nerr, ndone, active;
    expect_now();
    if (rst) begin
      m_phase = 0; m_n = 0; m_pushes = 0; m_pops = 0;
      m_first = 0; m_err = 0; m_done = 0; m_stall = 0;
    end else begin
      nerr = 0; ndone = 0;
      active = (m_phase == 1 || m_phase == 2) ? 1 : 0;
      case (m_phase)
        0: if (start) begin
             if (int'(n_in) >= 1 && int'(n_in) <= 8) begin
               m_phase = 1; m_n = int'(n_in); m_pushes = 0; m_pops = 0;
             end else nerr = 1;
           end
        1: if (e_push == 1) begin
             m_pushes++;
             if (m_pushes == m_n * m_n) begin m_phase = 2; m_first = 1; end
           end
        2: begin
             if (m_first == 1 && !fifo_ready) nerr = 1;
             m_first = 0;
             if (e_pop == 1) begin
               m_pops++;
               if (m_pops == m_n * m_n) begin m_phase = 3; ndone = 1; end
             end
           end
        default: m_phase = 0;
      endcase
`ifdef MATRIX_FIFO_CTRL_TIMEOUT_EN
      if (active == 1 && e_push == 0 && e_pop == 0) begin
        m_stall++;
        if (m_stall == 255) begin
          m_phase = 0; m_first = 0; nerr = 1; ndone = 0;
        end
      end else m_stall = 0;
`else
      if (active == 0) m_stall = 0;
`endif
      m_err = nerr; m_done = ndone;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_now();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  int s_cyc;
  task automatic do_start(input int n);
    start = 1'b1; n_in = 4'(n); s_cyc = cyc;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit toggle);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      if (toggle) out_ready = ~out_ready;
      cycle();
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int p0, d0, e0, exp2[4];
    exp2 = '{'h000, 'h011, 'h100, 'h111};

    // reset
    cycle();
    chk_on = 1;
    cycle();
    chk("reset_busy", int'(busy), 0);
    chk("reset_row_idx", int'(row_idx), 0);
    chk("reset_col_idx", int'(col_idx), 0);
    chk("reset_done_err", int'(done) + int'(err), 0);
    rst = 1'b0;
    cycle();

    // N=2 streaming
    pop_log.delete(); pop_cyc.delete();
    p0 = push_cnt; d0 = done_cnt;
    in_valid = 1'b1; out_ready = 1'b1;
    do_start(2);
    run_until_done(40, 1'b0);
    cycle();
    chk("n2_pushes", push_cnt - p0, 4);
    chk("n2_pops", pop_log.size(), 4);
    for (int k = 0; k < 4 && k < pop_log.size(); k++) chk("n2_pop_tag", pop_log[k], exp2[k]);
    chk("n2_done_latency", done_cyc - s_cyc, 9);
    chk("n2_done_once", done_cnt - d0, 1);
    if (pop_log.size() == 4) chk("n2_last_pop_to_done", done_cyc - pop_cyc[3], 1);

    // N=3 with consumer backpressure every other cycle
    pop_log.delete(); pop_cyc.delete();
    d0 = done_cnt;
    do_start(3);
    run_until_done(80, 1'b1);
    cycle();
    chk("n3_pops", pop_log.size(), 9);
    for (int k = 1; k < pop_log.size(); k++) chk("n3_pop_spacing", pop_cyc[k] - pop_cyc[k-1], 2);
    if (pop_log.size() == 9) chk("n3_last_tag", pop_log[8], 'h221);
    chk("n3_done_once", done_cnt - d0, 1);
    out_ready = 1'b1;

    // illegal N values
    p0 = push_cnt; e0 = err_cnt;
    do_start(0);
    cycle();
    chk("n0_err", err_cnt - e0, 1);
    chk("n0_err_latency", err_cyc - s_cyc, 1);
    do_start(9);
    cycle();
    chk("n9_err", err_cnt - e0, 2);
    chk("illegal_no_push", push_cnt - p0, 0);
    chk("illegal_busy", int'(busy), 0);

    // reset mid-load after 5 pushes
    p0 = push_cnt; d0 = done_cnt; e0 = err_cnt;
    do_start(4);
    for (int i = 0; i < 20 && push_cnt - p0 < 5; i++) cycle();
    rst = 1'b1; in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    cycle();
    chk("rst_pushes", push_cnt - p0, 5);
    chk("rst_no_done_err", (done_cnt - d0) + (err_cnt - e0), 0);
    in_valid = 1'b1;
    do_start(2);
    run_until_done(40, 1'b0);
    chk("rst_restart_done", done_cnt - d0, 1);

    // fifo_full stall during load
    cycle();
    p0 = push_cnt;
    do_start(2);
    cycle();
    fifo_full = 1'b1;
    repeat (3) cycle();
    chk("full_stall_pushes", push_cnt - p0, 1);
    fifo_full = 1'b0;
    run_until_done(40, 1'b0);
    chk("full_total_pushes", push_cnt - p0, 4);

    // N=1, FIFO not ready on drain entry, plus empty stall
    cycle();
    d0 = done_cnt; e0 = err_cnt;
    fifo_ready = 1'b0; fifo_empty = 1'b1;
    do_start(1);
    repeat (4) cycle();
    fifo_empty = 1'b0;
    run_until_done(20, 1'b0);
    chk("notready_err", err_cnt - e0, 1);
    chk("notready_err_cycle", err_cyc - s_cyc, 3);
    chk("notready_done", done_cnt - d0, 1);
    fifo_ready = 1'b1;
    cycle();

`ifdef MATRIX_FIFO_CTRL_TIMEOUT_EN
    // watchdog abort in LOAD
    e0 = err_cnt; d0 = done_cnt;
    in_valid = 1'b0;
    do_start(2);
    for (int i = 0; i < 400 && err_cnt == e0; i++) cycle();
    chk("wd_err", err_cnt - e0, 1);
    chk("wd_err_cycle", err_cyc - s_cyc, 256);
    chk("wd_no_done", done_cnt - d0, 0);
    chk("wd_busy", int'(busy), 0);
    cycle();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
